// File: rtl/flash_fetch_responder.sv
// -----------------------------------------------------------------------------
// flash_fetch_responder
// Fetches one 16-bit weight/bias word from a serial SPI flash with the READ
// command, and keeps the last fetched word in a one-entry cache so repeated
// requests for the same address complete without bus traffic.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst            asynchronous active-high reset
//   flash_ready    fetch request (level), only looked at while idle
//   flash_address  16-bit word address of the requested word
//   cache_inv      clears the cache valid bit
//   flashData_out  last fetched word, held until the next completion
//   data_valid     one-cycle pulse when flashData_out has been updated
//   busy           high whenever the block is not idle
//   spi_sclk/spi_cs_n/spi_mosi/spi_miso  serial flash bus (mode 0, sclk=clk/2)
// -----------------------------------------------------------------------------
module flash_fetch_responder #(
    parameter logic [7:0] READ_OPCODE = 8'h03
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flash_ready,
    input  logic [15:0] flash_address,
    input  logic        cache_inv,
    output logic [15:0] flashData_out,
    output logic        data_valid,
    output logic        busy,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CS_SETUP   = 3'd1;
    localparam logic [2:0] S_SHIFT_CMD  = 3'd2;
    localparam logic [2:0] S_SHIFT_ADDR = 3'd3;
    localparam logic [2:0] S_SHIFT_DATA = 3'd4;
    localparam logic [2:0] S_CS_HOLD    = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    logic [2:0]  r_state;
    logic [15:0] r_addr;
    logic [31:0] r_tx;        // opcode + byte address, shifted out MSB first
    logic [15:0] r_rx;        // incoming data word
    logic [5:0]  r_bitcnt;    // 0..47 across the whole 48-bit frame
    logic        r_phase;     // 0 = sclk low half, 1 = sclk high half
    logic [15:0] r_data;
    logic [15:0] r_cache_tag;
    logic [15:0] r_cache_data;
    logic        r_cache_vld;

    logic w_shifting;
    logic w_hit;

    assign w_shifting = (r_state == S_SHIFT_CMD) || (r_state == S_SHIFT_ADDR) ||
                        (r_state == S_SHIFT_DATA);

    // An invalidate arriving together with the request beats the lookup.
    assign w_hit = r_cache_vld && !cache_inv && (r_cache_tag == flash_address);

    // Outputs decode straight from registered state, so reset forces them
    // without waiting for a clock edge.
    assign flashData_out = r_data;
    assign data_valid    = (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE);
    assign spi_cs_n      = !(w_shifting || (r_state == S_CS_SETUP) || (r_state == S_CS_HOLD));
    assign spi_sclk      = w_shifting && r_phase;
    assign spi_mosi      = ((r_state == S_SHIFT_CMD) || (r_state == S_SHIFT_ADDR)) && r_tx[31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= 16'h0000;
            r_tx     <= 32'h0;
            r_rx     <= 16'h0000;
            r_bitcnt <= 6'd0;
            r_phase  <= 1'b0;
            r_data   <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flash_ready) begin
                        r_addr <= flash_address;
                        if (w_hit) begin
                            // Hit goes straight to DONE so the pulse and the
                            // one-cycle idle gap match the miss path.
                            r_data  <= r_cache_data;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CS_SETUP;
                        end
                    end
                end
                S_CS_SETUP: begin
                    // Word address -> byte address: 16'hFFFF becomes 24'h01FFFE.
                    r_tx     <= {READ_OPCODE, 7'b0, r_addr, 1'b0};
                    r_bitcnt <= 6'd0;
                    r_phase  <= 1'b0;
                    r_state  <= S_SHIFT_CMD;
                end
                S_SHIFT_CMD, S_SHIFT_ADDR, S_SHIFT_DATA: begin
                    r_phase <= ~r_phase;
                    // End of the high half: sample miso and advance one bit.
                    if (r_phase) begin
                        r_tx     <= {r_tx[30:0], 1'b0};
                        r_bitcnt <= r_bitcnt + 6'd1;
                        if (r_state == S_SHIFT_DATA)
                            r_rx <= {r_rx[14:0], spi_miso};
                        if (r_bitcnt == 6'd7)
                            r_state <= S_SHIFT_ADDR;
                        else if (r_bitcnt == 6'd31)
                            r_state <= S_SHIFT_DATA;
                        else if (r_bitcnt == 6'd47)
                            r_state <= S_CS_HOLD;
                    end
                end
                S_CS_HOLD: begin
                    r_data  <= r_rx;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Cache load happens on the edge leaving DONE, so an invalidate seen in
    // the same cycle loses to the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cache_vld  <= 1'b0;
            r_cache_tag  <= 16'h0000;
            r_cache_data <= 16'h0000;
        end else if (r_state == S_DONE) begin
            r_cache_vld  <= 1'b1;
            r_cache_tag  <= r_addr;
            r_cache_data <= r_data;
        end else if (cache_inv) begin
            r_cache_vld  <= 1'b0;
        end
    end

endmodule
